// File: rtl/remodel_banked_sram_pkg.sv
// Shared helpers for the banked SRAM model: word-interleaved address split
// and parameter sanity checks.
package remodel_banked_sram_pkg;

  function automatic logic [31:0] bank_of(input logic [31:0] addr, input int unsigned bank_sel_w);
    return addr & ((32'd1 << bank_sel_w) - 32'd1);
  endfunction

  function automatic logic [31:0] row_of(input logic [31:0] addr, input int unsigned bank_sel_w);
    return addr >> bank_sel_w;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/remodel_rr_arbiter.sv
// Round-robin arbiter, one-hot grant. Lowest requester at or above the
// pointer wins (wrapping); the pointer moves past the winner on each grant.
module remodel_rr_arbiter
  import remodel_banked_sram_pkg::*;
#(
  parameter int unsigned NumReq = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NumReq-1:0] i_req,
  output logic [NumReq-1:0] o_gnt
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] w_winner;
  logic            w_found;

  always_comb begin
    o_gnt    = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!w_found && i_req[i] && (i >= 32'(r_ptr))) begin
        w_found  = 1'b1;
        w_winner = PtrW'(i);
      end
    end
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!w_found && i_req[i] && (i < 32'(r_ptr))) begin
        w_found  = 1'b1;
        w_winner = PtrW'(i);
      end
    end
    // No grant during reset keeps writes from committing and the pointer at 0.
    if (w_found && !i_rst) begin
      o_gnt[w_winner] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (32'(w_winner) == NumReq - 1) ? '0 : w_winner + 1'b1;
    end
  end

endmodule

// File: rtl/remodel_banked_sram.sv
// Multi-port word-interleaved banked SRAM model with per-bank round-robin
// arbitration, fixed-latency read responses and a saturating conflict counter.
module remodel_banked_sram
  import remodel_banked_sram_pkg::*;
#(
  parameter int unsigned NumWords  = 4096,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned Latency   = 1,
  parameter int unsigned CntWidth  = 16,
  parameter string       SimInit   = "none",
  localparam int unsigned BeWidth      = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned AddrWidth    = $clog2(NumWords),
  localparam int unsigned BankSelW     = (NumBanks > 1) ? $clog2(NumBanks) : 0,
  localparam int unsigned WordsPerBank = NumWords / NumBanks
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumPorts-1:0]                 req_i,
  output logic [NumPorts-1:0]                 gnt_o,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
  output logic [NumPorts-1:0]                 rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o,
  output logic [CntWidth-1:0]                 conflict_cnt_o
);

  localparam int unsigned BankIdxW = (BankSelW > 0) ? BankSelW : 1;
  localparam int unsigned RowW     = (AddrWidth > BankSelW) ? AddrWidth - BankSelW : 1;
  localparam int unsigned SumW     = CntWidth + $clog2(NumPorts + 1);
  localparam logic [DataWidth-1:0] InitWord = (SimInit == "ones") ? '1 : '0;

  localparam bit ParamsOk = is_pow2(NumWords) && is_pow2(NumBanks) &&
                            (NumWords % NumBanks == 0) && (NumBanks <= NumWords) &&
                            (NumPorts >= 1) && (Latency >= 1) && (CntWidth >= 1) &&
                            (SimInit == "zeros" || SimInit == "ones" ||
                             SimInit == "random" || SimInit == "none");

  if (!ParamsOk) begin : g_bad_params
    $error("remodel_banked_sram: illegal parameter combination");
  end

  typedef struct packed {
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [BeWidth-1:0]   be;
  } req_t;

  req_t [NumPorts-1:0]                w_req;
  logic [NumPorts-1:0][BankIdxW-1:0]  w_port_bank;
  logic [NumPorts-1:0][RowW-1:0]      w_port_row;
  logic [NumBanks-1:0][NumPorts-1:0]  w_bank_req;
  logic [NumBanks-1:0][NumPorts-1:0]  w_bank_gnt;
  logic [NumBanks-1:0][DataWidth-1:0] w_bank_rdata;
  logic [SumW-1:0]                    w_stall_sum;
  logic [CntWidth-1:0]                r_cnt;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port_map
    assign w_req[p]       = '{we: we_i[p], addr: addr_i[p], wdata: wdata_i[p], be: be_i[p]};
    assign w_port_bank[p] = BankIdxW'(bank_of(32'(addr_i[p]), BankSelW));
    assign w_port_row[p]  = RowW'(row_of(32'(addr_i[p]), BankSelW));

    a_payload_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_i[p] && !gnt_o[p]) |=> (req_i[p] && $stable(w_req[p])));
  end

  always_comb begin
    w_bank_req = '0;
    for (int unsigned b = 0; b < NumBanks; b++) begin
      for (int unsigned p = 0; p < NumPorts; p++) begin
        w_bank_req[b][p] = req_i[p] && (32'(w_port_bank[p]) == b);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int unsigned b = 0; b < NumBanks; b++) begin
      gnt_o = gnt_o | w_bank_gnt[b];
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic                 w_sel_valid;
    logic                 w_sel_we;
    logic [RowW-1:0]      w_sel_row;
    logic [DataWidth-1:0] w_sel_wdata;
    logic [BeWidth-1:0]   w_sel_be;
    logic [DataWidth-1:0] w_wmask;

    remodel_rr_arbiter #(.NumReq(NumPorts)) u_arb (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_req (w_bank_req[b]),
      .o_gnt (w_bank_gnt[b])
    );

    always_comb begin
      w_sel_valid = 1'b0;
      w_sel_we    = 1'b0;
      w_sel_row   = '0;
      w_sel_wdata = '0;
      w_sel_be    = '0;
      for (int unsigned p = 0; p < NumPorts; p++) begin
        if (w_bank_gnt[b][p]) begin
          w_sel_valid = 1'b1;
          w_sel_we    = w_req[p].we;
          w_sel_row   = w_port_row[p];
          w_sel_wdata = w_req[p].wdata;
          w_sel_be    = w_req[p].be;
        end
      end
    end

    always_comb begin
      w_wmask = '0;
      for (int unsigned i = 0; i < DataWidth; i++) begin
        w_wmask[i] = w_sel_be[i / ByteWidth];
      end
    end

    // Only the initialiser differs; "none"/"random" leave contents to the simulator.
    if (SimInit == "zeros" || SimInit == "ones") begin : g_mem
      logic [DataWidth-1:0] r_mem [WordsPerBank] = '{default: InitWord};

      always_ff @(posedge clk_i) begin
        if (w_sel_valid && w_sel_we) begin
          r_mem[w_sel_row] <= (r_mem[w_sel_row] & ~w_wmask) | (w_sel_wdata & w_wmask);
        end
      end
      assign w_bank_rdata[b] = r_mem[w_sel_row];
    end else begin : g_mem
      logic [DataWidth-1:0] r_mem [WordsPerBank];

      always_ff @(posedge clk_i) begin
        if (w_sel_valid && w_sel_we) begin
          r_mem[w_sel_row] <= (r_mem[w_sel_row] & ~w_wmask) | (w_sel_wdata & w_wmask);
        end
      end
      assign w_bank_rdata[b] = r_mem[w_sel_row];
    end
  end

  // Data stages advance only behind a valid bit, so the last stage holds the
  // most recent response while rvalid_o is low.
  for (genvar p = 0; p < NumPorts; p++) begin : g_resp
    logic                 w_rd_gnt;
    logic [Latency-1:0]   r_vld;
    logic [DataWidth-1:0] r_data [Latency];

    assign w_rd_gnt = gnt_o[p] && !we_i[p];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_vld <= '0;
        for (int unsigned s = 0; s < Latency; s++) begin
          r_data[s] <= '0;
        end
      end else begin
        r_vld[0] <= w_rd_gnt;
        if (w_rd_gnt) begin
          r_data[0] <= w_bank_rdata[w_port_bank[p]];
        end
        for (int unsigned s = 1; s < Latency; s++) begin
          r_vld[s] <= r_vld[s-1];
          if (r_vld[s-1]) begin
            r_data[s] <= r_data[s-1];
          end
        end
      end
    end

    assign rvalid_o[p] = r_vld[Latency-1];
    assign rdata_o[p]  = r_data[Latency-1];
  end

  always_comb begin
    w_stall_sum = SumW'(r_cnt);
    for (int unsigned p = 0; p < NumPorts; p++) begin
      w_stall_sum = w_stall_sum + SumW'(req_i[p] && !gnt_o[p]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_stall_sum > SumW'({CntWidth{1'b1}})) begin
      r_cnt <= '1;
    end else begin
      r_cnt <= w_stall_sum[CntWidth-1:0];
    end
  end

  assign conflict_cnt_o = r_cnt;

endmodule

// File: tb/tb_remodel_banked_sram.sv
// Directed bench for remodel_banked_sram: 4 ports, 4 banks, Latency 2,
// 4-bit conflict counter so saturation is reachable quickly.
module tb_remodel_banked_sram;

  logic                  clk_i;
  logic                  rst_i;
  logic [3:0]            req_i;
  logic [3:0]            gnt_o;
  logic [3:0]            we_i;
  logic [3:0][5:0]       addr_i;
  logic [3:0][63:0]      wdata_i;
  logic [3:0][7:0]       be_i;
  logic [3:0]            rvalid_o;
  logic [3:0][63:0]      rdata_o;
  logic [3:0]            conflict_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  remodel_banked_sram #(
    .NumWords  (64),
    .DataWidth (64),
    .ByteWidth (8),
    .NumPorts  (4),
    .NumBanks  (4),
    .Latency   (2),
    .CntWidth  (4),
    .SimInit   ("zeros")
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .gnt_o          (gnt_o),
    .we_i           (we_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .be_i           (be_i),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] actv, input logic [63:0] expv);
    n_checks++;
    if (actv !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actv, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_all();
    req_i   = '0;
    we_i    = '0;
    addr_i  = '0;
    wdata_i = '0;
    be_i    = '0;
  endtask

  task automatic set_port(input int p, input logic we, input logic [5:0] a,
                          input logic [63:0] d, input logic [7:0] be);
    req_i[p]   = 1'b1;
    we_i[p]    = we;
    addr_i[p]  = a;
    wdata_i[p] = d;
    be_i[p]    = be;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_cnt [4] = '{0, 3, 5, 6};

    // Reset state; a write held across a reset edge must not be granted.
    clr_all();
    rst_i = 1'b1;
    step();
    set_port(0, 1'b1, 6'h03, '1, 8'hFF);
    #1;
    check_val("rst_gnt_forced_low", 64'(gnt_o), 64'h0);
    step();
    clr_all();
    step();
    check_val("rst_rvalid", 64'(rvalid_o), 64'h0);
    check_val("rst_cnt", 64'(conflict_cnt_o), 64'h0);
    check_val("rst_rdata0", rdata_o[0], 64'h0);
    rst_i = 1'b0;

    // 1: write then read, plus a read of the word written during reset.
    set_port(0, 1'b1, 6'h05, 64'h0000_0000_DEAD_BEEF, 8'hFF);
    #1;
    check_val("t1_wr_gnt", 64'(gnt_o), 64'h1);
    step();
    clr_all();
    set_port(1, 1'b0, 6'h05, '0, '0);
    set_port(2, 1'b0, 6'h03, '0, '0);
    #1;
    check_val("t1_rd_gnt", 64'(gnt_o), 64'h6);
    step();
    clr_all();
    check_val("t1_rvalid_early", 64'(rvalid_o), 64'h0);
    step();
    check_val("t1_rvalid", 64'(rvalid_o), 64'h6);
    check_val("t1_rdata1", rdata_o[1], 64'h0000_0000_DEAD_BEEF);
    check_val("t1_rdata2_no_rst_write", rdata_o[2], 64'h0);
    step();
    check_val("t1_rvalid_one_cycle", 64'(rvalid_o), 64'h0);
    check_val("t1_rdata1_hold", rdata_o[1], 64'h0000_0000_DEAD_BEEF);
    check_val("t1_cnt", 64'(conflict_cnt_o), 64'h0);

    // 2: full bank-0 conflict from reset.
    rst_i = 1'b1;
    step();
    for (int k = 0; k < 4; k++) set_port(k, 1'b0, 6'(4 * k), '0, '0);
    step();
    rst_i = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("t2_gnt_%0d", k), 64'(gnt_o), 64'(1 << k));
      check_val($sformatf("t2_cnt_%0d", k), 64'(conflict_cnt_o), 64'(exp_cnt[k]));
      step();
      req_i[k] = 1'b0;
    end
    check_val("t2_cnt_final", 64'(conflict_cnt_o), 64'd6);
    clr_all();
    step();
    step();

    // 3: conflict-free writes then reads across all four banks.
    for (int k = 0; k < 4; k++) set_port(k, 1'b1, 6'(16 + k), 64'h0123_0000_0000_00A0 + 64'(k), 8'hFF);
    #1;
    check_val("t3_wr_gnt", 64'(gnt_o), 64'hF);
    step();
    clr_all();
    for (int k = 0; k < 4; k++) set_port(k, 1'b0, 6'(16 + k), '0, '0);
    #1;
    check_val("t3_rd_gnt", 64'(gnt_o), 64'hF);
    step();
    clr_all();
    check_val("t3_rvalid_early", 64'(rvalid_o), 64'h0);
    step();
    check_val("t3_rvalid", 64'(rvalid_o), 64'hF);
    for (int k = 0; k < 4; k++)
      check_val($sformatf("t3_rdata_%0d", k), rdata_o[k], 64'h0123_0000_0000_00A0 + 64'(k));
    check_val("t3_cnt_unchanged", 64'(conflict_cnt_o), 64'd6);

    // 4: byte enables, and a granted be=0 write that changes nothing.
    set_port(2, 1'b1, 6'h21, 64'h1122_3344_5566_7788, 8'hFF);
    #1;
    check_val("t4_wr_gnt", 64'(gnt_o), 64'h4);
    step();
    clr_all();
    set_port(2, 1'b1, 6'h21, 64'hFFFF_FFFF_AAAA_AAAA, 8'h0F);
    step();
    clr_all();
    set_port(0, 1'b1, 6'h21, 64'h0, 8'h00);
    #1;
    check_val("t4_be0_gnt", 64'(gnt_o), 64'h1);
    step();
    clr_all();
    set_port(3, 1'b0, 6'h21, '0, '0);
    step();
    clr_all();
    step();
    check_val("t4_rvalid", 64'(rvalid_o), 64'h8);
    check_val("t4_rdata", rdata_o[3], 64'h1122_3344_AAAA_AAAA);

    // 5: reset while a read is in flight.
    set_port(1, 1'b0, 6'h05, '0, '0);
    #1;
    check_val("t5_gnt", 64'(gnt_o), 64'h2);
    step();
    clr_all();
    rst_i = 1'b1;
    step();
    check_val("t5_rvalid_flushed", 64'(rvalid_o), 64'h0);
    for (int k = 0; k < 4; k++)
      check_val($sformatf("t5_rdata_zero_%0d", k), rdata_o[k], 64'h0);
    check_val("t5_cnt_zero", 64'(conflict_cnt_o), 64'h0);
    rst_i = 1'b0;
    step();
    check_val("t5_rvalid_never", 64'(rvalid_o), 64'h0);
    set_port(1, 1'b0, 6'h05, '0, '0);
    #1;
    check_val("t5_regnt", 64'(gnt_o), 64'h2);
    step();
    clr_all();
    check_val("t5_rvalid_still_low", 64'(rvalid_o), 64'h0);
    step();
    check_val("t5_reread_valid", 64'(rvalid_o), 64'h2);
    check_val("t5_reread_data", rdata_o[1], 64'h0000_0000_DEAD_BEEF);

    // 6: two ports hammer bank 0 until the counter saturates.
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    set_port(0, 1'b0, 6'h00, '0, '0);
    set_port(1, 1'b0, 6'h04, '0, '0);
    #1;
    for (int k = 0; k < 20; k++) begin
      check_val($sformatf("t6_gnt_%0d", k), 64'(gnt_o), (k % 2 == 0) ? 64'h1 : 64'h2);
      check_val($sformatf("t6_cnt_%0d", k), 64'(conflict_cnt_o), (k < 15) ? 64'(k) : 64'd15);
      step();
    end
    req_i[1] = 1'b0;
    #1;
    check_val("t6_drain_gnt", 64'(gnt_o), 64'h1);
    step();
    clr_all();
    step();
    check_val("t6_cnt_saturated", 64'(conflict_cnt_o), 64'hF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/remodel_banked_sram.md
Name: remodel_banked_sram

Overview:
Multi-port, word-interleaved banked SRAM model. It supersedes the flat multi-port SRAM model for cluster-level memories that need many requesters.
Each port uses a req/gnt request handshake. Per-bank round-robin arbitration resolves bank conflicts, and read responses come back on a valid-qualified channel after a configurable latency. A saturating conflict counter is provided for performance analysis.
The block sits between accelerator/core request ports and the behavioural memory array. It is used in simulation and as the golden model for macro-based banks.

Parameters:
- NumWords, 4096: total words; power of 2; divisible by NumBanks.
- DataWidth, 64: word width in bits.
- ByteWidth, 8: byte width; BeWidth = ceil(DataWidth/ByteWidth).
- NumPorts, 4: requester ports (>=1).
- NumBanks, 4: banks; power of 2 (>=1).
- Latency, 1: cycles from granted read to rvalid_o (>=1).
- CntWidth, 16: conflict counter width.
- SimInit, "none": time-zero array contents. One of "zeros", "ones", "random" or "none" (X).
- Derived (do not override):
  - AddrWidth = clog2(NumWords).
  - BankSelW = clog2(NumBanks), or 0 when NumBanks = 1.
  - WordsPerBank = NumWords/NumBanks.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset; synchronous, active-high.
- req_i, in, NumPorts: request per port.
- gnt_o, out, NumPorts: grant; request accepted at this clock edge.
- we_i, in, NumPorts: write enable per port.
- addr_i, in, NumPorts x AddrWidth: word address.
- wdata_i, in, NumPorts x DataWidth: write data.
- be_i, in, NumPorts x BeWidth: byte enable; bit j covers byte j (LSB first).
- rvalid_o, out, NumPorts: read data valid.
- rdata_o, out, NumPorts x DataWidth: read data.
- conflict_cnt_o, out, CntWidth: saturating count of stalled requests.

Behaviour:
- Address map:
  - bank = addr_i[BankSelW-1:0]; row = addr_i[AddrWidth-1:BankSelW].
  - Consecutive words go to consecutive banks.
- Request protocol:
  - A port holds req_i, we_i, addr_i, wdata_i and be_i stable until gnt_o is high.
  - gnt_o is combinational from req_i, addr_i and arbiter state in the same cycle.
  - The transfer completes at the rising edge where req_i && gnt_o.
- Arbitration:
  - One grant per bank per cycle. Each bank has an independent round-robin pointer, initialised to 0 at reset.
  - Among the ports requesting a bank, the lowest index >= pointer (wrapping) wins.
  - After a grant, that bank's pointer becomes (winner+1) mod NumPorts. The pointer is unchanged when the bank has no request.
  - Ports targeting distinct banks are all granted in the same cycle.
- Write:
  - Committed at the grant edge, byte-masked by be_i. No rvalid is produced.
  - be_i = 0 is a legal no-op write that is still granted.
- Read:
  - Array sampled at the grant edge, before any write in that edge. A write and a read to the same bank cannot be granted together.
  - A read granted at edge N drives rvalid_o=1 with the data for exactly one cycle, after edge N+Latency-1 (Latency=1: rvalid_o is high in the cycle after the grant).
  - Reads to different rows are pipelined back-to-back: one response per port per cycle.
  - A read after a write to the same word in a later cycle returns the new data.
- rdata_o holds its last valid value while rvalid_o=0.
- conflict_cnt_o:
  - Each cycle, adds the number of ports with req_i && !gnt_o.
  - Saturates at all-ones and never wraps.
  - Not counted while rst_i is high.
- Reset (rst_i=1 at an edge):
  - Round-robin pointers go to 0; rvalid_o, rdata_o and conflict_cnt_o go to 0.
  - The response pipeline is flushed; in-flight reads are dropped and never signalled.
  - gnt_o is forced to 0 while rst_i=1, so no writes commit during reset.
  - Array contents are NOT affected by reset. SimInit applies only at time zero.
- Reset mid-operation: a port whose request is pending keeps req_i asserted and is re-arbitrated from pointer 0 after reset.
- Assertions (simulation only):
  - Payload stable while req_i && !gnt_o.
  - Parameter legality: powers of 2, divisibility, Latency >= 1.

Decomposition:
- Package remodel_banked_sram_pkg holds:
  - helper functions bank_of(addr) and row_of(addr);
  - the per-port request struct req_t (we, addr, wdata, be), parameterised via typedefs in the top.
- Sub-module remodel_rr_arbiter (NumReq parameter; req, gnt one-hot, pointer update on grant; synchronous active-high reset). It is instantiated once per bank.
- The bank arrays and the response shift registers are generate loops in the top. No separate module is needed.

Test Plan:
Default configuration is NumPorts=4, NumBanks=4, DataWidth=64, Latency=2 unless stated.
1. Write then read:
   - Port0 writes addr 0x005, data 0x00000000DEADBEEF, be=0xFF; gnt_o[0]=1 in the same cycle.
   - Next cycle, port1 reads 0x005; gnt_o[1]=1.
   - rvalid_o[1]=1 with rdata_o[1]=0x00000000DEADBEEF exactly 2 cycles after the grant, for one cycle.
2. Full bank conflict:
   - All ports hold reads to 0x000, 0x004, 0x008, 0x00C (all bank 0) from reset.
   - Grants go to ports 0, 1, 2, 3 in consecutive cycles.
   - conflict_cnt_o = 3+2+1 = 6.
3. Conflict-free access: ports 0-3 read 0x010-0x013 (banks 0-3) together. All four gnt_o=1 in one cycle, four rvalid_o 2 cycles later, and the counter is unchanged.
4. Byte enables:
   - Write 0x1122334455667788.
   - Then write data 0xFFFFFFFFAAAAAAAA with be=0x0F.
   - Read returns 0x11223344AAAAAAAA.
5. Reset mid-read:
   - Grant a read, then assert rst_i for 1 cycle at the next edge.
   - rvalid_o never asserts; rdata_o=0, conflict_cnt_o=0.
   - A subsequent read of the same word returns the pre-reset data.
6. Saturation: CntWidth=4, two ports continuously read bank 0. conflict_cnt_o reaches 0xF and stays there; grants keep alternating 0, 1, 0, 1.
